regfile_param: RTL
==================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL expose these parameters:
- DATA_W, 32, register width in bits; a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W.
- ZERO_R0, 1, when 1 register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.
- TAP_REG, 25, index of the register driven onto rout.
REQ-002 The block SHALL expose these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- RegWrite  in  1  write enable.
- wrAddr  in  ADDR_W  write address.
- wrData  in  DATA_W  write data.
- wrMask  in  DATA_W/8  byte enables; bit i covers byte i.
- rdAddrA  in  ADDR_W  read address, port A.
- rdDataA  out  DATA_W  read data, port A.
- rdAddrB  in  ADDR_W  read address, port B.
- rdDataB  out  DATA_W  read data, port B.
- dumpStart  in  1  request a full register dump.
- dumpValid  out  1  dump beat valid.
- dumpReady  in  1  consumer accepts the dump beat.
- dumpAddr  out  ADDR_W  index of the current beat.
- dumpData  out  DATA_W  register value of the current beat.
- dumpBusy  out  1  high in DUMP and DONE.
- dumpDone  out  1  one-cycle pulse at the end of a dump.
- rout  out  16  r[TAP_REG][15:0], continuous.

Function
REQ-003 The block SHALL hold DEPTH registers of DATA_W bits each.
REQ-004 Write on a rising clk edge when RegWrite=1: only bytes with wrMask[i]=1 are updated; other bytes keep their value.
REQ-005 When ZERO_R0=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0.
REQ-006 Read ports SHALL be combinational, independent, and may use any address, including equal addresses.
REQ-007 When BYPASS=1, RegWrite=1 and rdAddrX=wrAddr, rdDataX SHALL equal the stored value with the masked bytes of wrData merged in; forwarding is suppressed for address 0 when ZERO_R0=1.
REQ-008 When BYPASS=0, reads SHALL return the stored value before the edge.
REQ-009 rout SHALL follow the stored r[TAP_REG] with no bypass.
REQ-010 The dump FSM SHALL have states IDLE, DUMP and DONE, with a counter idx of ADDR_W bits.
REQ-011 In IDLE with dumpStart=1: go to DUMP, set idx=0, load dumpData=r[0] and dumpAddr=0, and drive dumpValid=1 from the next cycle.
REQ-012 In DUMP, a handshake is dumpValid & dumpReady at a rising edge.
REQ-013 While dumpValid=1 and dumpReady=0, dumpAddr and dumpData SHALL stay stable, even if the register is written.
REQ-014 On a handshake with idx<DEPTH-1, the block SHALL increment idx and load r[idx+1] as stored before that edge; a same-edge write is not reflected in the loaded beat.
REQ-015 On a handshake with idx=DEPTH-1, the FSM SHALL go to DONE and deassert dumpValid.
REQ-016 DONE SHALL last exactly one cycle with dumpDone=1, then return to IDLE.
REQ-017 dumpStart SHALL be ignored outside IDLE.
REQ-018 A dump is exactly DEPTH beats, addresses 0..DEPTH-1 in ascending order, with no wrap-around.
REQ-019 Register writes and reads SHALL proceed unaffected during a dump.

Reset
REQ-020 reset=1 SHALL asynchronously clear all registers to 0, set the FSM to IDLE and idx=0, and drive dumpValid, dumpBusy, dumpDone, dumpAddr and dumpData to 0.
REQ-021 Reset asserted mid-dump SHALL abort the dump with no dumpDone pulse; a new dumpStart is required afterwards.
REQ-022 After reset, rdDataA, rdDataB and rout SHALL read 0.

Verification
REQ-023 Write r5=0xDEADBEEF, mask 4'hF; then write r5 with wrData=0x11223344, mask 4'b0101 -> rdDataA(5)=0xDE22BE44.
REQ-024 BYPASS=1: RegWrite=1, wrAddr=7, wrData=0xA5A5A5A5, mask 4'hF, rdAddrB=7 in the same cycle -> rdDataB=0xA5A5A5A5 before the edge. BYPASS=0 -> rdDataB=0 before the edge.
REQ-025 ZERO_R0=1: write r0=0xFFFFFFFF -> rdDataA(0)=0 and dump beat 0 = 0. Write r25=0x0001BEEF -> rout=0xBEEF.
REQ-026 Preload rN=N; pulse dumpStart with dumpReady=1 -> 32 beats, addr 0..31, data=addr; dumpDone pulses for one cycle one cycle after the last beat. With dumpReady held 0 for 3 cycles at beat 4 -> beat 4 stays stable, and a write r4=0x99 during the stall does not change the held beat.
REQ-027 Assert reset during beat 10 of a dump -> dumpValid=0 immediately, all registers 0, no dumpDone; a new dumpStart restarts the dump at addr 0.

Source files
------------

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised byte-masked register file with two read ports,
// optional write bypass, a 16-bit tap output and a handshaked full-register dump streamer.
module regfile_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  parameter int TAP_REG = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_W-1:0]     wrAddr,
  input  logic [DATA_W-1:0]     wrData,
  input  logic [DATA_W/8-1:0]   wrMask,
  input  logic [ADDR_W-1:0]     rdAddrA,
  output logic [DATA_W-1:0]     rdDataA,
  input  logic [ADDR_W-1:0]     rdAddrB,
  output logic [DATA_W-1:0]     rdDataB,
  input  logic                  dumpStart,
  output logic                  dumpValid,
  input  logic                  dumpReady,
  output logic [ADDR_W-1:0]     dumpAddr,
  output logic [DATA_W-1:0]     dumpData,
  output logic                  dumpBusy,
  output logic                  dumpDone,
  output logic [15:0]           rout
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   r [DEPTH];
  logic [ADDR_W-1:0]   idx, idx_next, idx_inc;
  logic [DATA_W-1:0]   dump_data, dump_data_next;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_merged;

  // Gating the write enable here keeps r[0] at zero, so every reader of r[0] sees 0.
  assign wr_en = RegWrite && !(ZERO_R0 && (wrAddr == '0));

  always_comb begin
    wr_merged = r[wrAddr];
    for (int i = 0; i < NBYTES; i++) begin
      if (wrMask[i]) wr_merged[i*8 +: 8] = wrData[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r[i] <= '0;
    end else if (wr_en) begin
      r[wrAddr] <= wr_merged;
    end
  end

  assign rdDataA = (ZERO_R0 && (rdAddrA == '0)) ? '0 :
                   (BYPASS && wr_en && (rdAddrA == wrAddr)) ? wr_merged : r[rdAddrA];
  assign rdDataB = (ZERO_R0 && (rdAddrB == '0)) ? '0 :
                   (BYPASS && wr_en && (rdAddrB == wrAddr)) ? wr_merged : r[rdAddrB];

  assign rout = r[ADDR_W'(TAP_REG)][15:0];

  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      dump_data <= '0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      dump_data <= dump_data_next;
    end
  end

  // Beats are captured into dump_data so a stalled beat ignores later register writes.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    dump_data_next = dump_data;
    dumpValid      = 1'b0;
    dumpBusy       = 1'b0;
    dumpDone       = 1'b0;
    unique case (state)
      IDLE: begin
        if (dumpStart) begin
          state_next     = DUMP;
          idx_next       = '0;
          dump_data_next = r[0];
        end
      end
      DUMP: begin
        dumpValid = 1'b1;
        dumpBusy  = 1'b1;
        if (dumpReady) begin
          if (idx == ADDR_W'(DEPTH - 1)) begin
            state_next = DONE;
          end else begin
            idx_next       = idx_inc;
            dump_data_next = r[idx_inc];
          end
        end
      end
      DONE: begin
        dumpBusy   = 1'b1;
        dumpDone   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dumpAddr = idx;
  assign dumpData = dump_data;

endmodule
